mem_wait_responder: RTL
=======================

Name: mem_wait_responder

Overview:
- Memory-side responder for the multicycle ARM core's shared instruction/data memory port, i.e. the target end of the requests the main control FSM issues during fetch, memory read and memory write states.
- Accepts one word request at a time over a valid/ready handshake.
- Inserts a programmable number of wait states, performs the access on an internal word array, and returns a single-cycle response with read data or error status.
- Lets the core be verified against non-zero memory latency.

Parameters:
DEPTH_LOG2, 6, log2 of array depth in 32-bit words (64 words)
RD_LAT, 2, wait cycles for a read; legal range 1..15
WR_LAT, 1, wait cycles for a write; legal range 1..15

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high
req_valid  input  1  core presents a request
req_we  input  1  1 = write, 0 = read
req_addr  input  32  byte address
req_wdata  input  32  write data
req_ready  output  1  responder can accept a request this cycle
resp_valid  output  1  response strobe, exactly one cycle per accepted request
resp_rdata  output  32  read data, valid when resp_valid && !req_we of the captured request
resp_err  output  1  error flag, valid with resp_valid

Behaviour:
- Reset (asynchronous) values:
  - state = IDLE, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0, wait counter = 0.
  - Array contents are not reset; they are undefined until written.
- State machine: IDLE -> WAIT -> RESP -> IDLE.
- IDLE:
  - req_ready = 1.
  - On an edge with req_valid = 1: capture addr, we and wdata; counter := (we ? WR_LAT : RD_LAT) - 1; go to WAIT.
- WAIT:
  - req_ready = 0; req_valid and the other request inputs are ignored.
  - If counter != 0: decrement.
  - If counter == 0, on that edge:
    - perform the access;
    - for a write, the array is updated;
    - for a read, resp_rdata := array[word index];
    - go to RESP.
- RESP:
  - resp_valid = 1 and req_ready = 0 for exactly one cycle.
  - Next edge: IDLE.
- Latency: resp_valid is high in the cycle beginning LAT edges after the accept edge (LAT = RD_LAT or WR_LAT). req_ready reasserts one cycle later. Minimum request spacing is LAT+2 cycles.
- Word index = req_addr[DEPTH_LOG2+1:2].
- Error: resp_err = 1 if req_addr[1:0] != 0 or req_addr[31:DEPTH_LOG2+2] != 0.
  - No array write occurs.
  - resp_rdata := 0.
  - Timing is identical to a normal access of the same type.
- resp_err is registered with the response, 0 outside RESP.
- resp_rdata holds its value until the next read or error response; a write response leaves it unchanged.
- Back-to-back: a request held on req_valid through WAIT/RESP is accepted on the first IDLE edge. No request is queued while busy.
- Read-after-write to the same word returns the new data; accesses are strictly serialised.
- Reset mid-operation: return to IDLE immediately, resp_valid = 0, captured request dropped. A write not yet committed (still in WAIT) never reaches the array.
- Parameter values outside 1..15 are rejected by an elaboration-time check.

Decomposition:
- Shared package:
  - state localparams IDLE = 0, WAIT = 1, RESP = 2 (2-bit);
  - WORD_BYTES = 4;
  - 4-bit latency counter width constant.
- One sub-module, mem_word_ram: 2**DEPTH_LOG2 x 32 array with synchronous write enable and registered read port, driven only at the WAIT counter==0 edge.
- The FSM, counter and error check live in the top.

Test Plan:
- Reset, then idle: req_ready = 1, resp_valid = 0, resp_rdata = 0 and resp_err = 0 throughout.
- Write 0xDEADBEEF to addr 0x10 (WR_LAT = 1): accepted at edge E0, resp_valid = 1 in the cycle after E1, resp_err = 0, req_ready = 0 for 2 cycles. Then read 0x10 (RD_LAT = 2): resp_valid after E2, resp_rdata = 0xDEADBEEF.
- Read with addr 0x13 and read with addr 0x100 (beyond 64 words): resp_err = 1, resp_rdata = 0, same 2-cycle latency. Write 0x12345678 to 0x101: resp_err = 1, and a follow-up read of 0x100 is unchanged.
- req_valid held high for 20 cycles with alternating write/read to 0x3C: exactly one resp_valid per accepted request, accept-to-accept spacing 3 cycles for writes and 4 for reads, no dropped or duplicated responses.
- Write 0xAAAA5555 to 0x20, wait for resp_valid. Then write 0x11111111 to 0x20 with WR_LAT = 3 and assert reset one cycle into WAIT: responder returns to IDLE, no resp_valid, and a following read of 0x20 returns 0xAAAA5555.
- RD_LAT = 1: read response arrives one edge after accept; write to the last word (0xFC) then read it back returns the written value with resp_err = 0.

Source files
------------

// File: rtl/mem_wait_responder_pkg.sv
// Shared types and constants for the wait-state memory responder.
package mem_wait_responder_pkg;

    // Responder FSM states
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } state_e;

    // Bytes per memory word and the matching byte-offset width
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned OFFS_W     = $clog2(WORD_BYTES);

    // Wait-state counter width and the largest latency it can express
    localparam int unsigned LAT_W   = 4;
    localparam int unsigned LAT_MAX = (1 << LAT_W) - 1;

    // Counter preload for a given latency: the last wait cycle is counter == 0
    function automatic logic [LAT_W-1:0] lat_load(input int unsigned lat);
        return LAT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/mem_word_ram.sv
// Word-wide single-port RAM with synchronous write and a registered read port.
// The read register can be cleared so an error response reports zero data.
module mem_word_ram #(
    parameter int unsigned DEPTH_LOG2 = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic                  clr_i,
    input  logic [DEPTH_LOG2-1:0] addr_i,
    input  logic [31:0]           wdata_i,
    output logic [31:0]           rdata_o
);

    localparam int unsigned Depth = 1 << DEPTH_LOG2;

    logic [31:0] mem_q [Depth];
    logic [31:0] rdata_q;
    logic [31:0] rdata_d;

    // Array storage: contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Read-data next state: clear wins over read, otherwise hold
    always_comb begin
        rdata_d = rdata_q;
        if (clr_i) begin
            rdata_d = '0;
        end else if (re_i) begin
            rdata_d = mem_q[addr_i];
        end
    end

    // Read-data register, holds between read/error responses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_wait_responder.sv
// Memory-side responder for the core's shared memory port: accepts one word
// request, waits a programmable number of cycles, performs the access and
// returns a one-cycle response carrying read data or an error flag.
module mem_wait_responder
    import mem_wait_responder_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 6,
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned WR_LAT     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid_i,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        req_ready_o,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o
);

    // Reject latencies the 4-bit counter cannot express, and depths that do
    // not fit the 32-bit byte address.
    if (RD_LAT < 1 || RD_LAT > LAT_MAX) begin : g_bad_rd_lat
        $error("mem_wait_responder: RD_LAT must be in 1..15");
    end
    if (WR_LAT < 1 || WR_LAT > LAT_MAX) begin : g_bad_wr_lat
        $error("mem_wait_responder: WR_LAT must be in 1..15");
    end
    if (DEPTH_LOG2 < 1 || DEPTH_LOG2 > 32 - OFFS_W - 1) begin : g_bad_depth
        $error("mem_wait_responder: DEPTH_LOG2 out of range");
    end

    localparam logic [LAT_W-1:0] RdLoad = lat_load(RD_LAT);
    localparam logic [LAT_W-1:0] WrLoad = lat_load(WR_LAT);

    state_e           state_q, state_d;
    logic [LAT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             we_q, we_d;
    logic             err_q, err_d;

    logic                  commit;
    logic                  addr_err;
    logic [DEPTH_LOG2-1:0] word_idx;
    logic                  ram_we;
    logic                  ram_re;
    logic                  ram_clr;

    // Captured address is misaligned or lies beyond the array
    always_comb begin
        addr_err = (addr_q[OFFS_W-1:0] != '0) || ((addr_q >> (DEPTH_LOG2 + OFFS_W)) != '0);
    end

    assign word_idx = addr_q[DEPTH_LOG2+OFFS_W-1:OFFS_W];

    // Next-state logic: capture in idle, count down in wait, one response cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        err_d   = 1'b0;
        commit  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    we_d    = req_we_i;
                    cnt_d   = req_we_i ? WrLoad : RdLoad;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    // Last wait cycle: the access happens on this edge
                    commit  = 1'b1;
                    err_d   = addr_err;
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Erroneous accesses never touch the array and report zero data
    always_comb begin
        ram_we  = commit & we_q & ~addr_err;
        ram_re  = commit & ~we_q & ~addr_err;
        ram_clr = commit & addr_err;
    end

    // State register; reset drops any captured request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            err_q   <= err_d;
        end
    end

    mem_word_ram #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_ram (
        .clk    (clk),
        .reset  (reset),
        .we_i   (ram_we),
        .re_i   (ram_re),
        .clr_i  (ram_clr),
        .addr_i (word_idx),
        .wdata_i(wdata_q),
        .rdata_o(resp_rdata_o)
    );

    // Handshake outputs decoded from the state register
    always_comb begin
        req_ready_o  = (state_q == StIdle);
        resp_valid_o = (state_q == StResp);
        resp_err_o   = err_q;
    end

endmodule
